// File: rtl/jk_bank_arbiter_if.sv
// Command/response bundle between two JK command requesters and the bank arbiter.
// The master side issues commands; the slave side owns the bank and reports completion.
interface jk_bank_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
);
  logic            req0_valid;
  logic [1:0]      req0_op;
  logic [IDXW-1:0] req0_idx;
  logic            req0_ready;

  logic            req1_valid;
  logic [1:0]      req1_op;
  logic [IDXW-1:0] req1_idx;
  logic            req1_ready;

  logic [WIDTH-1:0] q;
  logic             done;
  logic             done_owner;
  logic             err;

  modport master (
    output req0_valid, req0_op, req0_idx,
    input  req0_ready,
    output req1_valid, req1_op, req1_idx,
    input  req1_ready,
    input  q, done, done_owner, err
  );

  modport slave (
    input  req0_valid, req0_op, req0_idx,
    output req0_ready,
    input  req1_valid, req1_op, req1_idx,
    output req1_ready,
    output q, done, done_owner, err
  );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Two-requester round-robin arbiter that owns a bank of WIDTH JK cells.
// A granted command is latched in IDLE and applied to its cell during the following APPLY cycle.
module jk_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic               clk,
  input  logic               rst,
  jk_bank_arbiter_if.slave   bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  state_t           state_q;
  logic             prio_q;
  logic [1:0]       op_q;
  logic [IDXW-1:0]  idx_q;
  logic             owner_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             done_q;
  logic             done_owner_q;
  logic             err_q;

  logic             grant0;
  logic             grant1;
  logic             idx_oob;

  function automatic logic jk_next(input logic [1:0] op, input logic cur);
    logic nxt;
    case (op)
      2'b01:   nxt = 1'b0;
      2'b10:   nxt = 1'b1;
      2'b11:   nxt = ~cur;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // Readies depend only on state, prio and the valids, so a requester can
  // change op/idx freely without affecting who is granted.
  assign grant0 = (state_q == IDLE) && bus.req0_valid && (!bus.req1_valid || !prio_q);
  assign grant1 = (state_q == IDLE) && bus.req1_valid && (!bus.req0_valid ||  prio_q);

  assign idx_oob = (32'(idx_q) >= 32'(WIDTH));

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    logic hit;
    assign hit     = (idx_q == IDXW'(gi));
    assign q_d[gi] = hit ? jk_next(op_q, q_q[gi]) : q_q[gi];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      op_q         <= 2'b00;
      idx_q        <= '0;
      owner_q      <= 1'b0;
      q_q          <= '0;
      done_q       <= 1'b0;
      done_owner_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            op_q    <= grant1 ? bus.req1_op  : bus.req0_op;
            idx_q   <= grant1 ? bus.req1_idx : bus.req0_idx;
            owner_q <= grant1;
            prio_q  <= grant0;
            state_q <= APPLY;
          end
        end
        APPLY: begin
          // An out-of-range index matches no cell, so q_d equals q_q.
          q_q          <= q_d;
          done_q       <= 1'b1;
          done_owner_q <= owner_q;
          err_q        <= idx_oob;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.q          = q_q;
  assign bus.done       = done_q;
  assign bus.done_owner = done_owner_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: rule-level model compared every cycle, plus directed literal checks.
// A second WIDTH=6 instance covers the out-of-range index case.
module tb_jk_bank_arbiter;

  logic clk;
  logic rst;

  jk_bank_arbiter_if #(.WIDTH(8), .IDXW(3)) bus ();
  jk_bank_arbiter_if #(.WIDTH(6), .IDXW(3)) bus6 ();

  jk_bank_arbiter #(.WIDTH(8), .IDXW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  jk_bank_arbiter #(.WIDTH(6), .IDXW(3)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_on = 0;
  bit m_bits [8];
  bit m_busy;
  bit m_prio;
  int m_op;
  int m_idx;
  int m_owner;
  bit m_done;
  bit m_err;
  int m_done_owner;
  int m_w;

  // Who gets the grant this cycle, or -1 for nobody.
  function automatic int winner(input bit v0, input bit v1);
    if (m_busy)    return -1;
    if (v0 && v1)  return m_prio ? 1 : 0;
    if (v0)        return 0;
    if (v1)        return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst === 1'b0) begin
      m_on = 1;
      foreach (m_bits[i]) m_bits[i] = 0;
      m_busy = 0; m_prio = 0; m_op = 0; m_idx = 0; m_owner = 0;
      m_done = 0; m_err = 0; m_done_owner = 0;
    end else if (m_on) begin
      m_w = winner(bus.req0_valid, bus.req1_valid);
      m_done = 0;
      m_err  = 0;
      if (m_busy) begin
        if (m_idx < 8) begin
          if (m_op == 1) m_bits[m_idx] = 0;
          else if (m_op == 2) m_bits[m_idx] = 1;
          else if (m_op == 3) m_bits[m_idx] = !m_bits[m_idx];
        end else begin
          m_err = 1;
        end
        m_done = 1;
        m_done_owner = m_owner;
        m_busy = 0;
      end else if (m_w >= 0) begin
        m_op    = (m_w == 1) ? int'(bus.req1_op)  : int'(bus.req0_op);
        m_idx   = (m_w == 1) ? int'(bus.req1_idx) : int'(bus.req0_idx);
        m_owner = m_w;
        m_prio  = (m_w == 0);
        m_busy  = 1;
      end
    end
  end

  always @(negedge clk) begin
    int w;
    logic [7:0] eq;
    if (m_on && rst === 1'b1) begin
      w = winner(bus.req0_valid, bus.req1_valid);
      for (int i = 0; i < 8; i++) eq[i] = m_bits[i];
      check("model_ready0", 32'(bus.req0_ready), 32'(w == 0));
      check("model_ready1", 32'(bus.req1_ready), 32'(w == 1));
      check("model_q",      32'(bus.q),          32'(eq));
      check("model_done",   32'(bus.done),       32'(m_done));
      check("model_err",    32'(bus.err),        32'(m_err));
      if (m_done) check("model_done_owner", 32'(bus.done_owner), 32'(m_done_owner));
    end
  end

  // ---------------- monitors ----------------
  bit   log_en = 0;
  int   grant_log [$];
  logic [7:0] q_log [$];
  int   owner_log [$];
  int   both_ready = 0;

  always @(negedge clk) begin
    if (bus.done) begin
      done_count++;
      $display("txn done owner=%0d q=%02h err=%0b", bus.done_owner, bus.q, bus.err);
    end
    if (bus6.done)
      $display("txn done(w6) owner=%0d q=%02h err=%0b", bus6.done_owner, bus6.q, bus6.err);
    if (bus.req0_ready && bus.req1_ready) both_ready++;
    if (log_en) begin
      if (bus.req0_valid && bus.req0_ready) grant_log.push_back(0);
      if (bus.req1_valid && bus.req1_ready) grant_log.push_back(1);
      if (bus.done) begin
        q_log.push_back(bus.q);
        owner_log.push_back(int'(bus.done_owner));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic drive(input int r, input bit v, input logic [1:0] op, input logic [2:0] idx);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_idx = idx;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_idx = idx;
    end
  endtask

  // One complete command on the 8-wide instance, checking T, T+1 and T+2.
  task automatic issue(input int r, input logic [1:0] op, input logic [2:0] idx,
                       input logic [7:0] exp_q, input string tag);
    int n;
    logic rdy;
    logic [7:0] q_at_t;
    @(posedge clk); #1;
    drive(r, 1'b1, op, idx);
    @(negedge clk);
    n = 0;
    rdy = (r == 0) ? bus.req0_ready : bus.req1_ready;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
      rdy = (r == 0) ? bus.req0_ready : bus.req1_ready;
    end
    check({tag, "_ready"}, 32'(rdy), 32'd1);
    q_at_t = bus.q;
    @(posedge clk); #1;
    drive(r, 1'b0, op, idx);
    @(negedge clk);
    check({tag, "_apply_readies"}, 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    check({tag, "_q_before"}, 32'(bus.q), 32'(q_at_t));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_q"},     32'(bus.q),          32'(exp_q));
    check({tag, "_done"},  32'(bus.done),       32'd1);
    check({tag, "_owner"}, 32'(bus.done_owner), 32'(r));
    check({tag, "_err"},   32'(bus.err),        32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int dc;
    logic [7:0] acc;
    rst = 1'b0;
    drive(0, 1'b0, 2'b00, 3'd0);
    drive(1, 1'b0, 2'b00, 3'd0);
    bus6.req0_valid = 1'b0; bus6.req0_op = 2'b00; bus6.req0_idx = 3'd0;
    bus6.req1_valid = 1'b0; bus6.req1_op = 2'b00; bus6.req1_idx = 3'd0;

    // Reset, then a single set of bit 3
    do_reset();
    @(negedge clk);
    check("rst_q",          32'(bus.q),          32'h00);
    check("rst_done",       32'(bus.done),       32'd0);
    check("rst_err",        32'(bus.err),        32'd0);
    check("rst_done_owner", 32'(bus.done_owner), 32'd0);
    check("rst_q6",         32'(bus6.q),         32'h00);
    issue(0, 2'b10, 3'd3, 8'h08, "t1_set3");

    // Out-of-range index on the WIDTH=6 instance
    @(posedge clk); #1;
    bus6.req1_valid = 1'b1; bus6.req1_op = 2'b10; bus6.req1_idx = 3'd7;
    @(negedge clk);
    check("oob_ready1", 32'(bus6.req1_ready), 32'd1);
    check("oob_ready0", 32'(bus6.req0_ready), 32'd0);
    @(posedge clk); #1;
    bus6.req1_valid = 1'b0;
    @(negedge clk);
    check("oob_err_early", 32'(bus6.err),  32'd0);
    check("oob_done_early", 32'(bus6.done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("oob_done",  32'(bus6.done),       32'd1);
    check("oob_err",   32'(bus6.err),        32'd1);
    check("oob_owner", 32'(bus6.done_owner), 32'd1);
    check("oob_q",     32'(bus6.q),          32'h00);
    @(posedge clk);
    @(negedge clk);
    check("oob_err_after",  32'(bus6.err),  32'd0);
    check("oob_done_after", 32'(bus6.done), 32'd0);

    // Full op coverage on bit 5
    do_reset();
    dc = done_count;
    issue(0, 2'b10, 3'd5, 8'h20, "ops_set");
    issue(0, 2'b11, 3'd5, 8'h00, "ops_tog1");
    issue(1, 2'b11, 3'd5, 8'h20, "ops_tog2");
    issue(0, 2'b01, 3'd5, 8'h00, "ops_reset");
    issue(1, 2'b00, 3'd5, 8'h00, "ops_hold");
    @(posedge clk); #1;
    check("ops_done_count", 32'(done_count - dc), 32'd5);

    // Continuous contention from reset
    drive(0, 1'b1, 2'b11, 3'd0);
    drive(1, 1'b1, 2'b11, 3'd1);
    grant_log.delete();
    q_log.delete();
    owner_log.delete();
    both_ready = 0;
    do_reset();
    log_en = 1;
    repeat (10) @(negedge clk);
    log_en = 0;
    @(posedge clk); #1;
    drive(0, 1'b0, 2'b11, 3'd0);
    drive(1, 1'b0, 2'b11, 3'd1);
    repeat (3) @(posedge clk);
    check("cont_grants", 32'(grant_log.size() >= 4), 32'd1);
    check("cont_dones",  32'(q_log.size() >= 4),     32'd1);
    if (grant_log.size() >= 4 && q_log.size() >= 4) begin
      check("cont_g0", 32'(grant_log[0]), 32'd0);
      check("cont_g1", 32'(grant_log[1]), 32'd1);
      check("cont_g2", 32'(grant_log[2]), 32'd0);
      check("cont_g3", 32'(grant_log[3]), 32'd1);
      check("cont_q0", 32'(q_log[0]), 32'h01);
      check("cont_q1", 32'(q_log[1]), 32'h03);
      check("cont_q2", 32'(q_log[2]), 32'h02);
      check("cont_q3", 32'(q_log[3]), 32'h00);
      check("cont_o0", 32'(owner_log[0]), 32'd0);
      check("cont_o1", 32'(owner_log[1]), 32'd1);
    end
    check("cont_both_ready", 32'(both_ready), 32'd0);

    // Reset in the middle of a command
    do_reset();
    acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      acc[i] = 1'b1;
      issue(i % 2, 2'b10, 3'(i), acc, "fill");
    end
    check("fill_q", 32'(bus.q), 32'hFF);
    @(posedge clk); #1;
    drive(0, 1'b1, 2'b11, 3'd0);
    @(negedge clk);
    check("mid_ready0", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 2'b11, 3'd0);
    rst = 1'b0;
    dc = done_count;
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 1'b1, 2'b10, 3'd2);
    drive(1, 1'b1, 2'b10, 3'd4);
    @(negedge clk);
    check("mid_q",      32'(bus.q),          32'h00);
    check("mid_done",   32'(bus.done),       32'd0);
    check("mid_ready0", 32'(bus.req0_ready), 32'd1);
    check("mid_ready1", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, 2'b10, 3'd2);
    drive(1, 1'b0, 2'b10, 3'd4);
    @(posedge clk);
    @(negedge clk);
    check("mid_after_q",     32'(bus.q),          32'h04);
    check("mid_after_owner", 32'(bus.done_owner), 32'd0);
    @(posedge clk); #1;
    check("mid_done_count", 32'(done_count - dc), 32'd1);

    // Withdrawn request during APPLY
    @(posedge clk); #1;
    drive(0, 1'b1, 2'b10, 3'd7);
    @(negedge clk);
    check("wd_ready0", 32'(bus.req0_ready), 32'd1);
    dc = done_count;
    @(posedge clk); #1;
    drive(0, 1'b0, 2'b10, 3'd7);
    drive(1, 1'b1, 2'b11, 3'd1);
    @(negedge clk);
    check("wd_ready1_apply", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); #1;
    drive(1, 1'b0, 2'b11, 3'd1);
    @(negedge clk);
    check("wd_q", 32'(bus.q), 32'h84);
    @(posedge clk);
    @(negedge clk);
    check("wd_no_done", 32'(bus.done), 32'd0);
    check("wd_q_hold",  32'(bus.q),    32'h84);
    @(posedge clk); #1;
    drive(0, 1'b1, 2'b00, 3'd0);
    drive(1, 1'b1, 2'b00, 3'd0);
    @(negedge clk);
    check("wd_prio_ready1", 32'(bus.req1_ready), 32'd1);
    check("wd_prio_ready0", 32'(bus.req0_ready), 32'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, 2'b00, 3'd0);
    drive(1, 1'b0, 2'b00, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    check("wd_done_count", 32'(done_count - dc), 32'd2);
    check("wd_final_q", 32'(bus.q), 32'h84);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
